// File: rtl/led_ctrl_pkg.sv
// Shared encodings and pattern helpers for the key-driven LED sequencer.
package led_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_FLOW_L = 2'd0,
        MODE_FLOW_R = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_BLINK  = 2'd3
    } mode_e;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_PAUSE = 1'b1
    } run_st_e;

    localparam int LEN_FLOW_L = 4;
    localparam int LEN_FLOW_R = 4;
    localparam int LEN_BOUNCE = 6;
    localparam int LEN_BLINK  = 2;

    localparam int NUM_KEYS  = 3;
    localparam int KEY_MODE  = 0;
    localparam int KEY_SPEED = 1;
    localparam int KEY_RUN   = 2;

    // Last valid pattern position; pos wraps to 0 after it.
    function automatic logic [2:0] pat_last(mode_e m);
        case (m)
            MODE_FLOW_L: return 3'(LEN_FLOW_L - 1);
            MODE_FLOW_R: return 3'(LEN_FLOW_R - 1);
            MODE_BOUNCE: return 3'(LEN_BOUNCE - 1);
            default:     return 3'(LEN_BLINK - 1);
        endcase
    endfunction

    function automatic logic [3:0] led_decode(mode_e m, logic [2:0] pos);
        case (m)
            MODE_FLOW_L: return 4'b0001 << pos[1:0];
            MODE_FLOW_R: return 4'b1000 >> pos[1:0];
            MODE_BOUNCE: begin
                case (pos)
                    3'd1:    return 4'b0010;
                    3'd2:    return 4'b0100;
                    3'd3:    return 4'b1000;
                    3'd4:    return 4'b0100;
                    3'd5:    return 4'b0010;
                    default: return 4'b0001;
                endcase
            end
            default: return pos[0] ? 4'b0000 : 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/led_mode_ctrl_if.sv
// Board-facing signals of the LED mode controller: raw keys in, LED drive and status out.
interface led_mode_ctrl_if;
    logic [2:0] key;
    logic [3:0] led;
    logic [1:0] mode;
    logic [1:0] speed;
    logic       running;

    modport master (output key, input led, mode, speed, running);
    modport slave  (input key, output led, mode, speed, running);
endinterface

// File: rtl/key_debounce.sv
// Active-low key debouncer: 2-FF sync, stability counter, one-cycle press pulse on stable fall.
module key_debounce #(
    parameter int DEBOUNCE_CYC = 4
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic key_n,
    output logic press
);
    localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

    logic [1:0]    sync_q;
    logic          stable_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync_q   <= 2'b11;
            stable_q <= 1'b1;
            cnt_q    <= '0;
            press    <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], key_n};
            press  <= 1'b0;
            // Count only while the synced level disagrees with the stable one.
            if (sync_q[1] == stable_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                stable_q <= sync_q[1];
                cnt_q    <= '0;
                press    <= ~sync_q[1];
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end
endmodule

// File: rtl/led_mode_ctrl.sv
// Key-driven LED pattern sequencer: mode/speed selection, run/pause, and pattern stepping.
module led_mode_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int DEBOUNCE_MS = 20,
    parameter int TICK_BASE   = 25_000_000
) (
    input  logic            sys_clk,
    input  logic            sys_rst_n,
    led_mode_ctrl_if.slave  io
);
    localparam int DEBOUNCE_CYC = CLK_FREQ_HZ / 1000 * DEBOUNCE_MS;
    localparam int TW           = $clog2(TICK_BASE);

    logic [NUM_KEYS-1:0] press;

    genvar k;
    generate
        for (k = 0; k < NUM_KEYS; k++) begin : g_key
            key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db (
                .sys_clk   (sys_clk),
                .sys_rst_n (sys_rst_n),
                .key_n     (io.key[k]),
                .press     (press[k])
            );
        end
    endgenerate

    run_st_e st_q, st_d;
    logic    running;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) st_q <= ST_RUN;
        else            st_q <= st_d;
    end

    always_comb begin
        st_d    = st_q;
        running = (st_q == ST_RUN);
        if (press[KEY_RUN]) st_d = (st_q == ST_RUN) ? ST_PAUSE : ST_RUN;
    end

    mode_e       mode_q;
    logic [1:0]  speed_q;
    logic [2:0]  pos_q;
    logic [3:0]  led_q;
    logic [TW-1:0] tick_cnt_q, tick_last;
    logic        clr, count_en, tick;

    // Terminal count for the current speed, taken at full counter width.
    assign tick_last = TW'((TICK_BASE >> speed_q) - 1);
    assign clr       = press[KEY_MODE] | press[KEY_SPEED];
    assign count_en  = running & ~press[KEY_RUN];
    assign tick      = count_en & ~clr & (tick_cnt_q == tick_last);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            tick_cnt_q <= '0;
        end else if (clr) begin
            tick_cnt_q <= '0;
        end else if (count_en) begin
            tick_cnt_q <= (tick_cnt_q == tick_last) ? '0 : tick_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            mode_q  <= MODE_FLOW_L;
            speed_q <= 2'd0;
            pos_q   <= 3'd0;
            led_q   <= 4'b0000;
        end else begin
            led_q <= led_decode(mode_q, pos_q);
            if (press[KEY_MODE])  mode_q  <= mode_e'(mode_q + 2'd1);
            if (press[KEY_SPEED]) speed_q <= speed_q + 2'd1;
            // Mode press wins over a coincident tick; speed press already masks tick.
            if (press[KEY_MODE])  pos_q <= 3'd0;
            else if (tick)        pos_q <= (pos_q == pat_last(mode_q)) ? 3'd0 : pos_q + 3'd1;
        end
    end

    assign io.led     = led_q;
    assign io.mode    = mode_q;
    assign io.speed   = speed_q;
    assign io.running = running;
endmodule
